// File: rtl/bus_arbiter_pkg.sv
// Shared types and defaults for the single-port SRAM arbiter between the
// openmips fetch and data-memory ports.
package bus_arbiter_pkg;

    localparam int ARB_ADDR_W  = 32;
    localparam int ARB_DATA_W  = 32;
    localparam int ARB_TIMEOUT = 255;
    localparam int ARB_CNT_W   = 8;

    typedef enum logic [2:0] {
        IDLE,
        MEM_BUSY,
        IF_BUSY,
        MEM_DONE,
        IF_DONE
    } arb_state_t;

    typedef enum logic {
        CHIP_DISABLED = 1'b0,
        CHIP_ENABLED  = 1'b1
    } chip_status_t;

    typedef struct packed {
        logic                  we;
        logic [3:0]            sel;
        logic [ARB_ADDR_W-1:0] addr;
        logic [ARB_DATA_W-1:0] wdata;
    } arb_req_t;

    // Fetches are always full-word reads.
    function automatic arb_req_t fetch_req(input logic [ARB_ADDR_W-1:0] addr);
        arb_req_t r;
        r.we    = 1'b0;
        r.sel   = 4'b1111;
        r.addr  = addr;
        r.wdata = '0;
        return r;
    endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// Core-side (rom/ram) and SRAM-side signal bundle of the arbiter.
interface bus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_ce_i;
    logic [ADDR_W-1:0] if_addr_i;
    logic [DATA_W-1:0] if_data_o;
    logic              if_stallreq_o;
    logic              flush_i;
    logic              mem_ce_i;
    logic              mem_we_i;
    logic [3:0]        mem_sel_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [DATA_W-1:0] mem_data_i;
    logic [DATA_W-1:0] mem_data_o;
    logic              mem_stallreq_o;
    logic              sram_ce_o;
    logic              sram_we_o;
    logic [3:0]        sram_sel_o;
    logic [ADDR_W-1:0] sram_addr_o;
    logic [DATA_W-1:0] sram_data_o;
    logic [DATA_W-1:0] sram_data_i;
    logic              sram_ack_i;
    logic              bus_err_o;

    modport slave (
        input  if_ce_i, if_addr_i, flush_i,
        input  mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
        input  sram_data_i, sram_ack_i,
        output if_data_o, if_stallreq_o, mem_data_o, mem_stallreq_o,
        output sram_ce_o, sram_we_o, sram_sel_o, sram_addr_o, sram_data_o,
        output bus_err_o
    );

    modport master (
        output if_ce_i, if_addr_i, flush_i,
        output mem_ce_i, mem_we_i, mem_sel_i, mem_addr_i, mem_data_i,
        output sram_data_i, sram_ack_i,
        input  if_data_o, if_stallreq_o, mem_data_o, mem_stallreq_o,
        input  sram_ce_o, sram_we_o, sram_sel_o, sram_addr_o, sram_data_o,
        input  bus_err_o
    );
endinterface

// File: rtl/arb_timeout_cnt.sv
// Wait-cycle counter for one SRAM transaction; o_expire flags the last
// permitted cycle without ack.
module arb_timeout_cnt
    import bus_arbiter_pkg::*;
#(
    parameter int LIMIT = ARB_TIMEOUT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam logic [ARB_CNT_W-1:0] LAST = ARB_CNT_W'(LIMIT - 1);

    logic [ARB_CNT_W-1:0] r_cnt;

    assign o_expire = i_en && (r_cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || o_expire) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates fetch and data requests onto one registered SRAM port; data
// requests win, fetch results can be discarded by a pipeline flush.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ARB_ADDR_W,
    parameter int DATA_W  = ARB_DATA_W,
    parameter int TIMEOUT = ARB_TIMEOUT
) (
    input  logic           clk,
    input  logic           rst,
    bus_arbiter_if.slave   bus
);
    arb_state_t        r_state;
    arb_state_t        w_next_state;
    arb_req_t          r_req;
    logic              r_sram_ce;
    logic [DATA_W-1:0] r_if_data;
    logic [DATA_W-1:0] r_mem_data;
    logic              r_bus_err;
    logic              r_discard;

    logic w_busy;
    logic w_ack;
    logic w_expire;
    logic w_discard_now;

    assign w_busy        = (r_state == MEM_BUSY) || (r_state == IF_BUSY);
    assign w_ack         = w_busy && bus.sram_ack_i;
    assign w_discard_now = r_discard || bus.flush_i;

    arb_timeout_cnt #(.LIMIT(TIMEOUT)) u_timeout (
        .clk      (clk),
        .rst_n    (rst),
        .i_clr    (!w_busy || w_ack),
        .i_en     (w_busy && !w_ack),
        .o_expire (w_expire)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.mem_ce_i == CHIP_ENABLED) begin
                    w_next_state = MEM_BUSY;
                end else if (bus.if_ce_i == CHIP_ENABLED) begin
                    w_next_state = IF_BUSY;
                end
            end
            MEM_BUSY: begin
                if (w_ack || w_expire) begin
                    w_next_state = MEM_DONE;
                end
            end
            IF_BUSY: begin
                // A flushed fetch returns straight to IDLE so ctrl never sees IF_DONE.
                if (w_ack || w_expire) begin
                    w_next_state = w_discard_now ? IDLE : IF_DONE;
                end
            end
            MEM_DONE, IF_DONE: w_next_state = IDLE;
            default:           w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_req      <= '0;
            r_sram_ce  <= CHIP_DISABLED;
            r_if_data  <= '0;
            r_mem_data <= '0;
            r_bus_err  <= 1'b0;
            r_discard  <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.mem_ce_i == CHIP_ENABLED) begin
                        r_req     <= '{we: bus.mem_we_i, sel: bus.mem_sel_i,
                                       addr: bus.mem_addr_i, wdata: bus.mem_data_i};
                        r_sram_ce <= CHIP_ENABLED;
                    end else if (bus.if_ce_i == CHIP_ENABLED) begin
                        r_req     <= fetch_req(bus.if_addr_i);
                        r_sram_ce <= CHIP_ENABLED;
                    end
                end
                MEM_BUSY: begin
                    if (w_ack) begin
                        r_sram_ce <= CHIP_DISABLED;
                        if (!r_req.we) begin
                            r_mem_data <= bus.sram_data_i;
                        end
                    end else if (w_expire) begin
                        r_sram_ce  <= CHIP_DISABLED;
                        r_bus_err  <= 1'b1;
                        r_mem_data <= '0;
                    end
                end
                IF_BUSY: begin
                    if (w_ack || w_expire) begin
                        r_sram_ce <= CHIP_DISABLED;
                        r_discard <= 1'b0;
                        r_bus_err <= w_expire && !w_ack;
                        if (!w_discard_now) begin
                            r_if_data <= w_ack ? bus.sram_data_i : '0;
                        end
                    end else if (bus.flush_i) begin
                        r_discard <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.sram_ce_o      = r_sram_ce;
    assign bus.sram_we_o      = r_req.we;
    assign bus.sram_sel_o     = r_req.sel;
    assign bus.sram_addr_o    = ADDR_W'(r_req.addr);
    assign bus.sram_data_o    = DATA_W'(r_req.wdata);
    assign bus.if_data_o      = r_if_data;
    assign bus.mem_data_o     = r_mem_data;
    assign bus.bus_err_o      = r_bus_err;
    assign bus.if_stallreq_o  = bus.if_ce_i && (r_state != IF_DONE);
    assign bus.mem_stallreq_o = bus.mem_ce_i && (r_state != MEM_DONE);

endmodule
